lif_spike_logger: RTL and testbench

Downstream capture stage for the leaky integrate-and-fire neuron. It watches the neuron's spike output (uio_out[7] of the neuron top) and detects each rising edge as a spike event. For every event it records the inter-spike interval (ISI) in clock cycles and buffers it in a small FIFO, which readout logic drains over a valid/ready handshake. It also keeps a saturating spike count and a sticky drop flag for rate checks on silicon.

---
 rtl/lif_spike_logger.sv | 81 ++++++++
 tb/tb_lif_spike_logger.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lif_spike_logger.sv
// lif_spike_logger: detects spike rising edges, timestamps each with its inter-spike
// interval and buffers the words in a FIFO drained over valid/ready.
module lif_spike_logger #(
    parameter int TS_WIDTH = 8,
    parameter int DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     spike_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TS_WIDTH:0]        out_data,
    output logic [7:0]               spike_count,
    output logic                     dropped,
    output logic [$clog2(DEPTH):0]   fill
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [TS_WIDTH-1:0] ISI_MAX = '1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic                spike_q, spike_d;
    logic [TS_WIDTH-1:0] isi_q, isi_d, isi_inc;
    logic                first_q, first_d;
    logic                drop_q, drop_d;
    logic [AW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]         fill_q, fill_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [TS_WIDTH:0]   mem_q [DEPTH];
    logic [TS_WIDTH:0]   mem_d [DEPTH];
    logic                evt, pop, push;

    // isi_q holds enabled cycles since the last event minus one, so the word carries isi_inc
    always_comb begin
        spike_d = spike_in;
        pop     = (fill_q != '0) & out_ready;
        evt     = en & spike_in & ~spike_q & ~clr;
        push    = evt & ((fill_q < FULL) | pop);
        isi_inc = (isi_q == ISI_MAX) ? isi_q : isi_q + 1'b1;
        isi_d   = clr ? '0 : !en ? isi_q : evt ? '0 : isi_inc;
        first_d = clr | (first_q & ~evt);
        drop_d  = ~clr & (drop_q | (evt & ~push));
        cnt_d   = clr ? '0 : (evt & (cnt_q != 8'hff)) ? cnt_q + 1'b1 : cnt_q;
        fill_d  = clr ? '0 : (push & ~pop) ? fill_q + 1'b1 : (pop & ~push) ? fill_q - 1'b1 : fill_q;
        wptr_d  = clr ? '0 : push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = clr ? '0 : pop ? rptr_q + 1'b1 : rptr_q;
        mem_d   = mem_q;
        if (push) mem_d[wptr_q] = {first_q, isi_inc};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spike_q <= 1'b0;
            isi_q   <= '0;
            first_q <= 1'b1;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
            fill_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            mem_q   <= '{default: '0};
        end else begin
            spike_q <= spike_d;
            isi_q   <= isi_d;
            first_q <= first_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            mem_q   <= mem_d;
        end
    end

    assign out_valid   = fill_q != '0;
    assign out_data    = mem_q[rptr_q];
    assign spike_count = cnt_q;
    assign dropped     = drop_q;
    assign fill        = fill_q;
endmodule

// File: tb/tb_lif_spike_logger.sv
// tb_lif_spike_logger: directed and random stimulus against an interval-counting
// reference model; a negedge monitor checks every handshaken word and the status outputs.
module tb_lif_spike_logger;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic       spike_in = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [8:0] out_data;
    logic [7:0] spike_count;
    logic       dropped;
    logic [2:0] fill;

    int checks = 0;
    int failures = 0;
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    int hits[$];
    int mfill = 0, misi = 0, mcnt = 0;
    bit mfirst = 1'b1, mdrop = 1'b0, mprev = 1'b0;

    lif_spike_logger #(.TS_WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .spike_in(spike_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .spike_count(spike_count), .dropped(dropped), .fill(fill)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mfill = 0; misi = 0; mcnt = 0; mfirst = 1'b1; mdrop = 1'b0; mprev = 1'b0;
        exp_q.delete();
    endtask

    // One clock edge of the reference: intervals count enabled cycles, events are fresh highs
    task automatic model_step();
        bit pop, ev;
        if (rst) begin
            model_reset();
        end else if (clr) begin
            model_reset();
            mprev = spike_in;
        end else begin
            pop = mfill > 0 && out_ready;
            ev  = en && spike_in && !mprev;
            if (en) misi = (misi < 255) ? misi + 1 : 255;
            if (ev) begin
                if (mfill < 4 || pop) begin
                    exp_q.push_back({mfirst, 8'(misi)});
                    mfill++;
                end else mdrop = 1'b1;
                mfirst = 1'b0;
                if (mcnt < 255) mcnt++;
                misi = 0;
            end
            if (pop) mfill--;
            mprev = spike_in;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic run(input int n);
        bit h;
        for (int c = 1; c <= n; c++) begin
            h = 1'b0;
            foreach (hits[i]) if (hits[i] == c) h = 1'b1;
            spike_in = h;
            tick();
        end
        spike_in = 1'b0;
    endtask

    initial forever begin
        @(negedge clk);
        chk("valid", out_valid, mfill != 0);
        chk("fill", fill, mfill);
        chk("count", spike_count, mcnt);
        chk("dropped", dropped, mdrop);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_word", out_data, -1);
            else chk("word", out_data, exp_q.pop_front());
            got_q.push_back(out_data);
        end
    end

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        en = 1'b1;
        hits = '{5};
        run(5);
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 9'h105);
        chk("t1_count", spike_count, 1);
        out_ready = 1'b1;
        repeat (2) tick();

        do_clr();
        got_q.delete();
        hits = '{10, 11, 12, 17, 18, 19, 30, 31, 32};
        run(40);
        chk("t2_n", got_q.size(), 3);
        chk("t2_w0", got_q[0], 9'h10a);
        chk("t2_w1", got_q[1], 9'h007);
        chk("t2_w2", got_q[2], 9'h00d);

        out_ready = 1'b0;
        do_clr();
        hits = '{3, 6, 10, 15, 21, 28};
        run(30);
        chk("t3_fill", fill, 4);
        chk("t3_dropped", dropped, 1);
        chk("t3_count", spike_count, 6);
        got_q.delete();
        out_ready = 1'b1;
        repeat (6) tick();
        out_ready = 1'b0;
        chk("t3_n", got_q.size(), 4);
        chk("t3_w0", got_q[0], 9'h103);
        chk("t3_w1", got_q[1], 9'h003);
        chk("t3_w2", got_q[2], 9'h004);
        chk("t3_w3", got_q[3], 9'h005);

        do_clr();
        hits = '{2, 4, 6, 8};
        run(12);
        out_ready = 1'b1;
        spike_in = 1'b1;
        tick();
        out_ready = 1'b0;
        spike_in = 1'b0;
        chk("t4_fill", fill, 4);
        chk("t4_dropped", dropped, 0);
        got_q.delete();
        out_ready = 1'b1;
        repeat (6) tick();
        chk("t4_n", got_q.size(), 4);
        chk("t4_last", got_q[3], 9'h005);

        do_clr();
        got_q.delete();
        hits = '{2, 302};
        run(305);
        chk("t5_n", got_q.size(), 2);
        chk("t5_w0", got_q[0], 9'h102);
        chk("t5_sat", got_q[1], 9'h0ff);

        out_ready = 1'b0;
        do_clr();
        hits = '{2, 4, 6, 8, 10};
        run(11);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t6_fill", fill, 3);
        chk("t6_dropped", dropped, 1);
        do_clr();
        chk("t6_clr_fill", fill, 0);
        chk("t6_clr_valid", out_valid, 0);
        chk("t6_clr_dropped", dropped, 0);
        chk("t6_clr_count", spike_count, 0);
        got_q.delete();
        out_ready = 1'b1;
        hits = '{4};
        run(6);
        chk("t6_n", got_q.size(), 1);
        chk("t6_first", got_q[0], 9'h104);

        do_clr();
        en = 1'b0;
        spike_in = 1'b1;
        repeat (2) tick();
        en = 1'b1;
        repeat (2) tick();
        spike_in = 1'b0;
        chk("t7_en_rise", spike_count, 0);

        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 1000; i++) begin
                en        = $urandom_range(0, 9) != 0;
                spike_in  = $urandom_range(0, p == 3 ? 40 : 2) == 0;
                out_ready = $urandom_range(0, 3) < (p == 1 ? 1 : 3);
                clr       = $urandom_range(0, 199) == 0;
                if ($urandom_range(0, 499) == 0) begin
                    rst = 1'b1;
                    model_reset();
                    tick();
                    rst = 1'b0;
                end
                tick();
            end
        end
        clr = 1'b0;
        out_ready = 1'b1;
        spike_in = 1'b0;
        repeat (6) tick();
        chk("final_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
